// File: rtl/riscv_test_checker.sv
// Self-checking result monitor for a RISC-V core: compares OUTPUT_PORT against a
// loaded table of (retired-instruction count, expected value) pairs during a run.
module riscv_test_checker #(
    parameter int NUM_TEST = 26,
    parameter int IDX_W    = 5,
    parameter int TIMEOUT  = 100000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             TBL_WE,
    input  logic [IDX_W-1:0] TBL_IDX,
    input  logic [31:0]      TBL_NUM_INST,
    input  logic [31:0]      TBL_ANS,
    input  logic             START,
    input  logic [31:0]      NUM_INST,
    input  logic [31:0]      OUTPUT_PORT,
    input  logic             HALT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             TIMEOUT_ERR,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [31:0]      FAIL_VALUE,
    output logic [IDX_W:0]   PASS_CNT,
    output logic [31:0]      CYCLE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout_err;
    logic [IDX_W-1:0]    r_fail_idx;
    logic [31:0]         r_fail_value;
    logic [IDX_W:0]      r_pass_cnt;
    logic [31:0]         r_cycle;

    logic [31:0]         r_tbl_num [NUM_TEST];
    logic [31:0]         r_tbl_ans [NUM_TEST];
    logic [NUM_TEST-1:0] r_valid;
    logic [NUM_TEST-1:0] r_passed;

    logic [NUM_TEST-1:0] w_wr_sel;
    logic [NUM_TEST-1:0] w_hit_sel;
    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [31:0]         w_hit_ans;
    logic                w_mismatch;
    logic                w_match_ok;
    logic                w_timeout;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_TEST; i++) begin
            w_wr_sel[i] = TBL_WE && (r_state != S_RUN) && (TBL_IDX == IDX_W'(i));
        end
    end

    // Scanning from the top down leaves the lowest matching index as the winner.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_ans = '0;
        w_hit_sel = '0;
        for (int i = NUM_TEST - 1; i >= 0; i--) begin
            if (r_valid[i] && !r_passed[i] && (r_tbl_num[i] == NUM_INST)) begin
                w_hit        = 1'b1;
                w_hit_idx    = IDX_W'(i);
                w_hit_ans    = r_tbl_ans[i];
                w_hit_sel    = '0;
                w_hit_sel[i] = 1'b1;
            end
        end
    end

    assign w_mismatch = w_hit && (OUTPUT_PORT != w_hit_ans);
    assign w_match_ok = w_hit && !w_mismatch;
    assign w_timeout  = (r_cycle == 32'(TIMEOUT - 1));

    // NOTE: table payload has no reset; only the valid bits gate its use, so
    // clearing them is enough and keeps the storage a plain memory.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_TEST; i++) begin
            if (w_wr_sel[i]) begin
                r_tbl_num[i] <= TBL_NUM_INST;
                r_tbl_ans[i] <= TBL_ANS;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_fail_idx    <= '0;
            r_fail_value  <= '0;
            r_pass_cnt    <= '0;
            r_cycle       <= '0;
            r_valid       <= '0;
            r_passed      <= '0;
        end else begin
            r_valid <= r_valid | w_wr_sel;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_state       <= S_RUN;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_fail_idx    <= '0;
                        r_fail_value  <= '0;
                        r_pass_cnt    <= '0;
                        r_cycle       <= '0;
                        r_passed      <= '0;
                    end
                end
                S_RUN: begin
                    if (r_cycle != '1) begin
                        r_cycle <= r_cycle + 32'd1;
                    end
                    if (w_match_ok) begin
                        r_passed   <= r_passed | w_hit_sel;
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                    end
                    if (w_mismatch) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_fail_idx   <= w_hit_idx;
                        r_fail_value <= OUTPUT_PORT;
                    end else if (HALT) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state       <= S_DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_pass        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign PASS        = r_pass;
    assign TIMEOUT_ERR = r_timeout_err;
    assign FAIL_IDX    = r_fail_idx;
    assign FAIL_VALUE  = r_fail_value;
    assign PASS_CNT    = r_pass_cnt;
    assign CYCLE       = r_cycle;

endmodule

// File: tb/tb_riscv_test_checker.sv
// Directed bench: a default-timeout checker and an 8-cycle-timeout checker share stimulus.
`timescale 1ns/1ps
module tb_riscv_test_checker;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        TBL_WE;
    logic [4:0]  TBL_IDX;
    logic [31:0] TBL_NUM_INST;
    logic [31:0] TBL_ANS;
    logic        START;
    logic [31:0] NUM_INST;
    logic [31:0] OUTPUT_PORT;
    logic        HALT;

    logic        busy, done, pass, to_err;
    logic [4:0]  fail_idx;
    logic [31:0] fail_value;
    logic [5:0]  pass_cnt;
    logic [31:0] cycle;

    logic        t8_busy, t8_done, t8_pass, t8_to_err;
    logic [4:0]  t8_fail_idx;
    logic [31:0] t8_fail_value;
    logic [5:0]  t8_pass_cnt;
    logic [31:0] t8_cycle;

    int n_pass = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    riscv_test_checker dut (
        .CLK(CLK), .RSTn(RSTn), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
        .TBL_NUM_INST(TBL_NUM_INST), .TBL_ANS(TBL_ANS), .START(START),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .BUSY(busy), .DONE(done), .PASS(pass), .TIMEOUT_ERR(to_err),
        .FAIL_IDX(fail_idx), .FAIL_VALUE(fail_value), .PASS_CNT(pass_cnt),
        .CYCLE(cycle)
    );

    riscv_test_checker #(.TIMEOUT(8)) dut8 (
        .CLK(CLK), .RSTn(RSTn), .TBL_WE(TBL_WE), .TBL_IDX(TBL_IDX),
        .TBL_NUM_INST(TBL_NUM_INST), .TBL_ANS(TBL_ANS), .START(START),
        .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
        .BUSY(t8_busy), .DONE(t8_done), .PASS(t8_pass), .TIMEOUT_ERR(t8_to_err),
        .FAIL_IDX(t8_fail_idx), .FAIL_VALUE(t8_fail_value), .PASS_CNT(t8_pass_cnt),
        .CYCLE(t8_cycle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_entry(input logic [4:0] idx, input logic [31:0] num, input logic [31:0] ans);
        TBL_WE = 1'b1; TBL_IDX = idx; TBL_NUM_INST = num; TBL_ANS = ans;
        step();
        TBL_WE = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0; TBL_WE = 1'b0; TBL_IDX = '0; TBL_NUM_INST = '0; TBL_ANS = '0;
        START = 1'b0; NUM_INST = 32'hFFFF_FFFF; OUTPUT_PORT = '0; HALT = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_cycle", cycle, 32'd0);
        RSTn = 1'b1;

        // Two passing entries then HALT
        write_entry(5'd0, 32'd1, 32'h0);
        write_entry(5'd2, 32'd3, 32'h5);
        pulse_start();
        check("run_busy", 32'(busy), 32'd1);
        check("run_done", 32'(done), 32'd0);
        NUM_INST = 32'd1; OUTPUT_PORT = 32'h0;
        step();
        check("p1_cnt", 32'(pass_cnt), 32'd1);
        NUM_INST = 32'd3; OUTPUT_PORT = 32'h5;
        step();
        check("p2_cnt", 32'(pass_cnt), 32'd2);
        NUM_INST = 32'd100; HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("halt_done", 32'(done), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_pass", 32'(pass), 32'd1);
        check("halt_cnt", 32'(pass_cnt), 32'd2);
        check("halt_cycle", cycle, 32'd3);
        step();
        step();
        check("hold_cycle", cycle, 32'd3);
        check("hold_pass", 32'(pass), 32'd1);

        // Single mismatch
        write_entry(5'd0, 32'd2, 32'h14);
        pulse_start();
        NUM_INST = 32'd2; OUTPUT_PORT = 32'h13;
        step();
        check("mm_done", 32'(done), 32'd1);
        check("mm_pass", 32'(pass), 32'd0);
        check("mm_idx", 32'(fail_idx), 32'd0);
        check("mm_val", fail_value, 32'h13);
        check("mm_cnt", 32'(pass_cnt), 32'd0);

        // Mismatch and HALT together: mismatch wins
        pulse_start();
        check("clr_val", fail_value, 32'h0);
        NUM_INST = 32'd3; OUTPUT_PORT = 32'h6; HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("mh_pass", 32'(pass), 32'd0);
        check("mh_idx", 32'(fail_idx), 32'd2);
        check("mh_val", fail_value, 32'h6);

        // Table write during RUN is dropped
        pulse_start();
        NUM_INST = 32'd100;
        write_entry(5'd2, 32'd7, 32'h99);
        HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("wr_run_pass", 32'(pass), 32'd1);
        pulse_start();
        NUM_INST = 32'd3; OUTPUT_PORT = 32'h5;
        step();
        check("keep_cnt1", 32'(pass_cnt), 32'd1);
        NUM_INST = 32'd7; OUTPUT_PORT = 32'h99; START = 1'b1;
        step();
        START = 1'b0;
        check("start_ign_cnt", 32'(pass_cnt), 32'd1);
        check("start_ign_cyc", cycle, 32'd2);
        HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("keep_pass", 32'(pass), 32'd1);
        check("keep_cnt2", 32'(pass_cnt), 32'd1);

        // Lowest index wins; out-of-range write ignored
        write_entry(5'd1, 32'd3, 32'h5);
        write_entry(5'd2, 32'd3, 32'h9);
        write_entry(5'd26, 32'd50, 32'h1);
        pulse_start();
        NUM_INST = 32'd3; OUTPUT_PORT = 32'h5;
        step();
        check("low_cnt1", 32'(pass_cnt), 32'd1);
        check("low_busy", 32'(busy), 32'd1);
        OUTPUT_PORT = 32'h9;
        step();
        check("low_cnt2", 32'(pass_cnt), 32'd2);
        NUM_INST = 32'd50; OUTPUT_PORT = 32'h2; HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("oor_pass", 32'(pass), 32'd1);
        check("oor_cnt", 32'(pass_cnt), 32'd2);

        // Timeout on the 8-cycle instance
        pulse_start();
        NUM_INST = 32'hDEAD_0000;
        repeat (7) step();
        check("to_pre_busy", 32'(t8_busy), 32'd1);
        check("to_pre_cyc", t8_cycle, 32'd7);
        step();
        check("to_done", 32'(t8_done), 32'd1);
        check("to_busy", 32'(t8_busy), 32'd0);
        check("to_err", 32'(t8_to_err), 32'd1);
        check("to_pass", 32'(t8_pass), 32'd0);
        check("to_cycle", t8_cycle, 32'd8);
        check("dflt_busy", 32'(busy), 32'd1);
        check("dflt_err", 32'(to_err), 32'd0);
        HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("dflt_pass", 32'(pass), 32'd1);
        check("dflt_cycle", cycle, 32'd9);
        check("to_hold_cyc", t8_cycle, 32'd8);
        check("to_hold_err", 32'(t8_to_err), 32'd1);

        // Reset in the middle of a run
        pulse_start();
        NUM_INST = 32'd3; OUTPUT_PORT = 32'h5;
        step();
        check("pre_rst_cnt", 32'(pass_cnt), 32'd1);
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_cnt", 32'(pass_cnt), 32'd0);
        check("mrst_cycle", cycle, 32'd0);
        check("mrst_t8_busy", 32'(t8_busy), 32'd0);
        pulse_start();
        NUM_INST = 32'd2; OUTPUT_PORT = 32'h13;
        step();
        NUM_INST = 32'd3; OUTPUT_PORT = 32'h0;
        step();
        HALT = 1'b1;
        step();
        HALT = 1'b0;
        check("post_done", 32'(done), 32'd1);
        check("post_pass", 32'(pass), 32'd1);
        check("post_cnt", 32'(pass_cnt), 32'd0);
        check("post_idx", 32'(fail_idx), 32'd0);
        check("post_cycle", cycle, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
